// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//
// Handshake: start is sampled only while IDLE; the edge that samples start=1 also
// latches bin_in. busy is high for the BIN_W shift cycles, then done pulses for
// exactly one cycle while bcd_out/overflow show the fresh result. start seen while
// busy or done is dropped, never queued. bcd_out/overflow only change on the edge
// that enters DONE, so they never expose partial results.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [1:0]            state_o
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [SCR_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   scratch_shift;
    logic               ovf_shift;

    // Add-3 correction on every digit >= 5, then the one-bit shift of {scratch, shift reg}.
    // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_shift = {adj[SCR_W-2:0], shift_q[BIN_W-1]};
        ovf_shift     = ovf_q | adj[SCR_W-1];
    end

    // State and datapath registers; reset clears everything and overrides any event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state and datapath update: accept in IDLE, shift BIN_W times, publish on DONE entry.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CNT_INIT;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d   = shift_q << 1;
                scratch_d = scratch_shift;
                ovf_d     = ovf_shift;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    bcd_d      = ovf_shift ? ALL_NINES : scratch_shift;
                    overflow_d = ovf_shift;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed bench for bin_to_bcd_seq across four parameter sets.
// Instance 0: BIN_W=8 DIGITS=3, 1: BIN_W=5 DIGITS=2, 2: BIN_W=8 DIGITS=2, 3: BIN_W=16 DIGITS=5.
module tb_bin_to_bcd_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        start_v [4];
    logic [7:0]  bin0;
    logic [4:0]  bin1;
    logic [7:0]  bin2;
    logic [15:0] bin3;

    logic        busy_v [4];
    logic        done_v [4];
    logic        ovf_v  [4];
    logic [1:0]  st_v   [4];
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [7:0]  bcd2;
    logic [19:0] bcd3;
    logic [31:0] bcd_v  [4];

    always_comb begin
        bcd_v[0] = {20'd0, bcd0};
        bcd_v[1] = {24'd0, bcd1};
        bcd_v[2] = {24'd0, bcd2};
        bcd_v[3] = {12'd0, bcd3};
    end

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_8_3 (
        .clk(clk), .reset(reset), .start(start_v[0]), .bin_in(bin0),
        .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0), .overflow(ovf_v[0]), .state_o(st_v[0])
    );
    bin_to_bcd_seq #(.BIN_W(5), .DIGITS(2)) u_5_2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .bin_in(bin1),
        .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1), .overflow(ovf_v[1]), .state_o(st_v[1])
    );
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_8_2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .bin_in(bin2),
        .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2), .overflow(ovf_v[2]), .state_o(st_v[2])
    );
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_16_5 (
        .clk(clk), .reset(reset), .start(start_v[3]), .bin_in(bin3),
        .busy(busy_v[3]), .done(done_v[3]), .bcd_out(bcd3), .overflow(ovf_v[3]), .state_o(st_v[3])
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bin(input int sel, input int val);
        case (sel)
            0: bin0 = 8'(val);
            1: bin1 = 5'(val);
            2: bin2 = 8'(val);
            default: bin3 = 16'(val);
        endcase
    endtask

    // One-cycle start pulse; returns #1 after the accepting edge.
    task automatic drive_start(input int sel, input int val);
        set_bin(sel, val);
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
    endtask

    // Waits (bounded) for done and checks how many edges it took.
    task automatic wait_done(input int sel, input int exp_edges, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (done_v[sel] === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) chk({tag, "_latency"}, 32'(n), 32'(exp_edges));
    endtask

    task automatic check_result(input int sel, input logic [31:0] exp_bcd, input logic exp_ovf,
                                input string tag);
        chk({tag, "_bcd"}, bcd_v[sel], exp_bcd);
        chk({tag, "_ovf"}, 32'(ovf_v[sel]), 32'(exp_ovf));
        chk({tag, "_busy_in_done"}, 32'(busy_v[sel]), 32'd0);
    endtask

    // Full conversion: start, wait, check result, check return to IDLE and hold.
    task automatic convert(input int sel, input int val, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input int lat, input string tag);
        drive_start(sel, val);
        chk({tag, "_busy"}, 32'(busy_v[sel]), 32'd1);
        wait_done(sel, lat, tag);
        check_result(sel, exp_bcd, exp_ovf, tag);
        tick();
        chk({tag, "_done_drop"}, 32'(done_v[sel]), 32'd0);
        chk({tag, "_idle"}, 32'(st_v[sel]), 32'd0);
        tick();
        tick();
        chk({tag, "_hold_bcd"}, bcd_v[sel], exp_bcd);
    endtask

    task automatic watch_no_done(input int sel, input int ncyc, input string tag);
        int pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (done_v[sel] === 1'b1) pulses++;
        end
        chk({tag, "_no_extra_done"}, 32'(pulses), 32'd0);
    endtask

    // Reference decimal-to-BCD by repeated division.
    function automatic logic [31:0] to_bcd(input int v, input int digits);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Run-time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int last;
        bit seen;
        int n;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        bin0 = '0; bin1 = '0; bin2 = '0; bin3 = '0;

        // Reset state of every instance.
        reset = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
            chk($sformatf("rst%0d_bcd", i), bcd_v[i], 32'd0);
            chk($sformatf("rst%0d_ovf", i), 32'(ovf_v[i]), 32'd0);
            chk($sformatf("rst%0d_state", i), 32'(st_v[i]), 32'd0);
        end
        reset = 1'b0;
        tick();

        // T1: 5-bit, 2 digits.
        convert(1, 31, 32'h31, 1'b0, 5, "t1_31");
        convert(1, 0, 32'h00, 1'b0, 5, "t1_0");

        // T3: 8-bit, 2 digits, saturation boundary.
        convert(2, 99, 32'h99, 1'b0, 8, "t3_99");
        convert(2, 100, 32'h99, 1'b1, 8, "t3_100");
        convert(2, 255, 32'h99, 1'b1, 8, "t3_255");
        convert(2, 42, 32'h42, 1'b0, 8, "t3_42_after_ovf");

        // T6: 16-bit, 5 digits.
        convert(3, 65535, 32'h65535, 1'b0, 16, "t6_65535");
        convert(3, 0, 32'h00000, 1'b0, 16, "t6_0");
        convert(3, 10000, 32'h10000, 1'b0, 16, "t6_10000");

        // T2: full sweep back-to-back with start held high.
        bin0 = 8'd0;
        start_v[0] = 1'b1;
        last = 0;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            seen = 1'b0;
            while (n < 30 && !seen) begin
                tick();
                n++;
                if (done_v[0] === 1'b1) seen = 1'b1;
            end
            chk($sformatf("t2_%0d_done_seen", v), 32'(seen), 32'd1);
            if (!seen) break;
            chk($sformatf("t2_%0d_bcd", v), bcd_v[0], to_bcd(v, 3));
            chk($sformatf("t2_%0d_ovf", v), 32'(ovf_v[0]), 32'd0);
            if (v > 0) chk($sformatf("t2_%0d_period", v), 32'(cyc - last), 32'd10);
            last = cyc;
            if (v < 255) bin0 = 8'(v + 1);
            else start_v[0] = 1'b0;
        end
        tick(); tick();

        // T4: bin_in change and start pulse during SHIFT are ignored.
        drive_start(0, 200);
        bin0 = 8'd7;
        tick(); tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("t4_busy_mid", 32'(busy_v[0]), 32'd1);
        wait_done(0, 5, "t4");
        check_result(0, 32'h200, 1'b0, "t4");
        tick();
        watch_no_done(0, 12, "t4");

        // T5: reset in the 4th SHIFT cycle discards the conversion.
        drive_start(0, 123);
        tick(); tick(); tick();
        chk("t5_busy_before_rst", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(busy_v[0]), 32'd0);
        chk("t5_done", 32'(done_v[0]), 32'd0);
        chk("t5_bcd", bcd_v[0], 32'd0);
        chk("t5_ovf", 32'(ovf_v[0]), 32'd0);
        chk("t5_state", 32'(st_v[0]), 32'd0);
        watch_no_done(0, 15, "t5");
        convert(0, 123, 32'h123, 1'b0, 8, "t5_after");
        convert(0, 9, 32'h009, 1'b0, 8, "t5_nine");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
